regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//   Multi-cycle sequencer that drives the single-read-port 8x32 register file: executes rd = rs1 OP rs2.
//   Reads both operands over two cycles, computes in a small ALU, writes the result back through the write port.
//   Sits between instruction issue (Start/Op/addresses) and the register file.
//   Provides the ALU flags and a Start/Busy/Done handshake.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; must match register file width
//   ADDR_WIDTH  3   register address width (8 registers)
// PORTS
//   Clk        in   1           single clock; all state updates on rising edge
//   Rst        in   1           reset: synchronous, active-low
//   Start      in   1           request; sampled only in IDLE
//   Op         in   3           000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MOV
//   Rd         in   ADDR_WIDTH  destination register
//   Rs1        in   ADDR_WIDTH  operand A register
//   Rs2        in   ADDR_WIDTH  operand B register (ignored for MOV)
//   Busy       out  1           high in any state other than IDLE
//   Done       out  1           one-cycle pulse after the write-back cycle
//   Result     out  DATA_WIDTH  last computed result, held until the next EXEC
//   Flag_Z     out  1           Result == 0, captured in EXEC
//   Flag_C     out  1           ADD carry-out; SUB borrow (A < B unsigned); 0 for other ops
//   RF_R_Addr  out  ADDR_WIDTH  register file read address
//   RF_R_Data  in   DATA_WIDTH  register file read data (combinational w.r.t. RF_R_Addr)
//   RF_W_Addr  out  ADDR_WIDTH  register file write address
//   RF_W_En    out  1           register file write enable
//   RF_W_Data  out  DATA_WIDTH  register file write data
// BEHAVIOUR
//   Reset (Rst==0 at a rising edge): state=IDLE.
//     Busy, Done, RF_W_En, Flag_Z, Flag_C = 0; Result = 0.
//     Latched Op/Rd/Rs1/Rs2 and operand registers A/B = 0.
//     Reset mid-operation aborts with no write: RF_W_En is 0 from that edge.
//   FSM: IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> IDLE; no stalls.
//   IDLE: if Start=1, latch Op/Rd/Rs1/Rs2 and go to READ_A; otherwise stay.
//   READ_A: RF_R_Addr = Rs1_latched; capture RF_R_Data into A at the edge.
//   READ_B: RF_R_Addr = Rs2_latched; capture RF_R_Data into B at the edge.
//   In all other states RF_R_Addr = Rs1_latched.
//   EXEC: compute with DATA_WIDTH wrap-around and register Result, Flag_Z, Flag_C.
//     SHL/SHR shift A by B[4:0]; MOV: Result = A.
//   WRITE: RF_W_En=1, RF_W_Addr=Rd_latched, RF_W_Data=Result (register file updates at the edge).
//     RF_W_En is 0 in every other state. RF_W_Addr/RF_W_Data hold the latched values at all times.
//   Done=1 in the cycle after WRITE (state back in IDLE), 0 otherwise.
//   Latency: Start accepted at edge N -> write at edge N+4 -> Done high during cycle N+4..N+5.
//   Back-to-back: Start may be asserted in the Done cycle; new READ_A sees the value just written.
//   Start while Busy=1 is ignored; no queueing. Op/address inputs are don't-care outside IDLE.
//   Rd may equal Rs1 or Rs2: both reads complete before the write.
// TESTING
//   Preload R1=5, R2=7; Start ADD Rd=3 Rs1=1 Rs2=2 -> RF_W_En one cycle at Start+4, R3=12, Z=0, C=0, Done next cycle.
//   R1=0xFFFFFFFF, R2=1, ADD Rd=4 -> R4=0, Flag_Z=1, Flag_C=1.
//     SUB R2-R1 (7-0xFFFFFFFF) -> 0x00000008, C=1.
//   R1=0x80000001, R2=4: SHL -> 0x00000010; SHR -> 0x08000000; MOV Rd=5 Rs1=1 -> R5=0x80000001.
//   Start pulsed during READ_B -> ignored: exactly one write, Busy stays 1 for 4 cycles.
//   Back-to-back: ADD R3=R1+R2 then ADD R3=R3+R3 issued in the Done cycle -> R3=24.
//   Rst=0 during EXEC -> no RF write occurs, Busy=0 after the edge, Result=0, next Start works normally.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle rd = rs1 OP rs2 sequencer for a single-read-port register file.
// The outputs are registered from next-state values, so each one lines up with its FSM state.
module regfile_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [ADDR_WIDTH-1:0] Rd,
    input  logic [ADDR_WIDTH-1:0] Rs1,
    input  logic [ADDR_WIDTH-1:0] Rs2,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Flag_Z,
    output logic                  Flag_C,
    output logic [ADDR_WIDTH-1:0] RF_R_Addr,
    input  logic [DATA_WIDTH-1:0] RF_R_Data,
    output logic [ADDR_WIDTH-1:0] RF_W_Addr,
    output logic                  RF_W_En,
    output logic [DATA_WIDTH-1:0] RF_W_Data
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    // Returns {carry, result}; carry is the ADD carry-out or the SUB unsigned borrow.
    function automatic logic [DATA_WIDTH:0] alu_f(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] r;
        r = {(DATA_WIDTH+1){1'b0}};
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, a << b[4:0]};
            OP_SHR:  r = {1'b0, a >> b[4:0]};
            OP_MOV:  r = {1'b0, a};
            default: r = {(DATA_WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  flag_z_q, flag_z_d;
    logic                  flag_c_q, flag_c_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH:0]   alu_s;

    // Next-state, operand capture and ALU evaluation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        alu_s    = alu_f(op_q, a_q, b_q);
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    rd_d    = Rd;
                    rs1_d   = Rs1;
                    rs2_d   = Rs2;
                    state_d = S_READ_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ_A: begin
                a_d     = RF_R_Data;
                state_d = S_READ_B;
            end
            S_READ_B: begin
                b_d     = RF_R_Data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_s[DATA_WIDTH-1:0];
                flag_z_d = (alu_s[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
                flag_c_d = alu_s[DATA_WIDTH];
                state_d  = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_WRITE);
        wen_d   = (state_d == S_WRITE);
        // Look ahead one state so the read address is valid for the whole capture cycle.
        raddr_d = (state_d == S_READ_B) ? rs2_d : rs1_d;
    end

    // State and output registers; reset also aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            rd_q     <= {ADDR_WIDTH{1'b0}};
            rs1_q    <= {ADDR_WIDTH{1'b0}};
            rs2_q    <= {ADDR_WIDTH{1'b0}};
            a_q      <= {DATA_WIDTH{1'b0}};
            b_q      <= {DATA_WIDTH{1'b0}};
            result_q <= {DATA_WIDTH{1'b0}};
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
            raddr_q  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wen_q    <= wen_d;
            raddr_q  <= raddr_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Result    = result_q;
    assign Flag_Z    = flag_z_q;
    assign Flag_C    = flag_c_q;
    assign RF_R_Addr = raddr_q;
    assign RF_W_Addr = rd_q;
    assign RF_W_En   = wen_q;
    assign RF_W_Data = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench: behavioural 8x32 register file, table of ALU vectors,
// write-back scoreboard and hand-written sequences for the multi-cycle corner cases.
module tb_regfile_op_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        busy, done, flag_z, flag_c, wen;
    logic [31:0] result, r_data, w_data;
    logic [2:0]  r_addr, w_addr;

    logic [31:0] rf [8];
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [31:0] pre_data;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] er;
        logic        ez;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        z;
        logic        c;
    } sb_t;

    vec_t vecs [13];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_op_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Op(op), .Rd(rd), .Rs1(rs1), .Rs2(rs2),
        .Busy(busy), .Done(done), .Result(result), .Flag_Z(flag_z), .Flag_C(flag_c),
        .RF_R_Addr(r_addr), .RF_R_Data(r_data), .RF_W_Addr(w_addr), .RF_W_En(wen),
        .RF_W_Data(w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign r_data = rf[r_addr];

    always @(posedge clk) begin
        if (pre_en) rf[pre_addr] <= pre_data;
        else if (wen) rf[w_addr] <= w_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h at %0t", w_addr, w_data, $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("wb_addr", {29'd0, w_addr}, {29'd0, e.addr});
                check("wb_data", w_data, e.data);
                check("result", result, e.data);
                check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                check("flag_c", {31'd0, flag_c}, {31'd0, e.c});
            end
        end
    end

    task automatic preload(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a negedge; Start is accepted at the following rising edge.
    task automatic start_op(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                            input logic [2:0] b, input logic [31:0] er, input logic ez,
                            input logic ec, input logic expect_write);
        sb_t e;
        start = 1'b1; op = o; rd = d; rs1 = a; rs2 = b;
        if (expect_write) begin
            e.addr = d; e.data = er; e.z = ez; e.c = ec;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
    endtask

    task automatic wait_done(input logic [2:0] d, input logic [31:0] er);
        int cyc;
        cyc = 0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (wen !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("write_latency", cyc, 32'd3);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("wen_low", {31'd0, wen}, 32'd0);
        check("rf_dest", rf[d], er);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 3'd3, 3'd1, 3'd2, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1]  = '{3'd0, 3'd4, 3'd1, 3'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1};
        vecs[2]  = '{3'd1, 3'd4, 3'd2, 3'd1, 32'd7,        32'hFFFFFFFF, 32'd8,        1'b0, 1'b1};
        vecs[3]  = '{3'd5, 3'd6, 3'd1, 3'd2, 32'h80000001, 32'd4,        32'h00000010, 1'b0, 1'b0};
        vecs[4]  = '{3'd6, 3'd6, 3'd1, 3'd2, 32'h80000001, 32'd4,        32'h08000000, 1'b0, 1'b0};
        vecs[5]  = '{3'd7, 3'd5, 3'd1, 3'd2, 32'h80000001, 32'd4,        32'h80000001, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 3'd7, 3'd1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 3'd7, 3'd1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 3'd7, 3'd1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 3'd0, 3'd1, 3'd2, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b1};
        vecs[10] = '{3'd1, 3'd0, 3'd1, 3'd2, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0};
        vecs[11] = '{3'd5, 3'd0, 3'd1, 3'd2, 32'd1,        32'h00000024, 32'h00000010, 1'b0, 1'b0};
        vecs[12] = '{3'd0, 3'd1, 3'd1, 3'd2, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0};

        for (int i = 0; i < 8; i++) rf[i] = 32'd0;
        rst = 1'b0; start = 1'b0; op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
        pre_en = 1'b0; pre_addr = 3'd0; pre_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        check("rst_waddr", {29'd0, w_addr}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            preload(vecs[i].rs1, vecs[i].va);
            preload(vecs[i].rs2, vecs[i].vb);
            @(negedge clk);
            start_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                     vecs[i].er, vecs[i].ez, vecs[i].ec, 1'b1);
            wait_done(vecs[i].rd, vecs[i].er);
        end

        // Back-to-back: second Start issued in the Done cycle must read the fresh R3.
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        @(negedge clk);
        start_op(3'd0, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b0, 1'b1);
        wait_done(3'd3, 32'd12);
        start_op(3'd0, 3'd3, 3'd3, 3'd3, 32'd24, 1'b0, 1'b0, 1'b1);
        wait_done(3'd3, 32'd24);

        // Start pulsed during READ_B is ignored: one write, Busy high for exactly 4 cycles.
        @(negedge clk);
        start_op(3'd0, 3'd6, 3'd1, 3'd2, 32'd12, 1'b0, 1'b0, 1'b1);
        check("ign_busy0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ign_busy1", {31'd0, busy}, 32'd1);
        start = 1'b1; op = 3'd1; rd = 3'd7; rs1 = 3'd2; rs2 = 3'd1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ign_busy3", {31'd0, busy}, 32'd1);
        check("ign_wen", {31'd0, wen}, 32'd1);
        @(negedge clk);
        check("ign_busy4", {31'd0, busy}, 32'd0);
        check("ign_done", {31'd0, done}, 32'd1);
        repeat (6) @(negedge clk);
        check("ign_still_idle", {31'd0, busy}, 32'd0);

        // Reset asserted while in EXEC: abort without a write, then recover.
        preload(3'd3, 32'hDEADBEEF);
        @(negedge clk);
        start_op(3'd0, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_wen", {31'd0, wen}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_write", rf[3], 32'hDEADBEEF);
        start_op(3'd0, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b0, 1'b1);
        wait_done(3'd3, 32'd12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
